// File: rtl/wave_display_mc_pkg.sv
// -----------------------------------------------------------------------------
// wave_display_mc_pkg
//   Shared definitions for the multi-channel waveform overlay renderer:
//   default sample/value widths, the line length, the default channel colours
//   and the packed RGB type used for the registered colour output.
// -----------------------------------------------------------------------------
package wave_display_mc_pkg;

  localparam int VALUE_W_DEF  = 8;
  localparam int SAMPLE_W_DEF = 8;
  localparam int X_MAX_DEF    = 1279;

  localparam logic [23:0] COLOR_CH0   = 24'h8A2BE2;
  localparam logic [23:0] COLOR_CH1   = 24'h00FF00;
  localparam logic [23:0] COLOR_BLACK = 24'h000000;

  // Channel 0 sits in the least significant 24 bits.
  localparam logic [47:0] COLORS_DEF = {COLOR_CH1, COLOR_CH0};

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

endpackage

// File: rtl/wave_display_mc_span_ch.sv
// -----------------------------------------------------------------------------
// wave_display_mc_span_ch
//   One trace of the overlay. Keeps the sample of the previous column
//   (curHold) and the sample that opened the current vertical span (prev),
//   and decides whether the current row falls between them.
// Ports
//   clk, reset      pixel clock, asynchronous active-high reset
//   i_curValue      RAM sample belonging to the current column
//   i_newSample     current column starts a new sample index
//   i_firstSample   current column is the first drawn column of a run
//   i_enable        channel display enable
//   i_row           row scaled into sample units
//   o_hit           row lies inside the span [min(prev,cur), max(prev,cur)]
// -----------------------------------------------------------------------------
module wave_display_mc_span_ch #(
  parameter int VALUE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] i_curValue,
  input  logic               i_newSample,
  input  logic               i_firstSample,
  input  logic               i_enable,
  input  logic [VALUE_W-1:0] i_row,
  output logic               o_hit
);

  logic [VALUE_W-1:0] r_curHold;
  logic [VALUE_W-1:0] r_prev;
  logic [VALUE_W-1:0] w_prevEff;
  logic [VALUE_W-1:0] w_lo;
  logic [VALUE_W-1:0] w_hi;

  // curHold trails the RAM data by one column. When a new sample index
  // begins, that trailing value is the last sample of the previous index and
  // becomes the start of the vertical span. The first column of a run has no
  // predecessor, so its own value is used and the sample is drawn as a dot
  // for both of its columns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_curHold <= '0;
      r_prev    <= '0;
    end else begin
      r_curHold <= i_curValue;
      if (i_firstSample)
        r_prev <= i_curValue;
      else if (i_newSample)
        r_prev <= r_curHold;
    end
  end

  // Same-cycle bypass so the first column of a sample already sees the
  // value that r_prev is only about to capture.
  always_comb begin
    w_prevEff = r_prev;
    if (i_firstSample)
      w_prevEff = i_curValue;
    else if (i_newSample)
      w_prevEff = r_curHold;
  end

  assign w_lo  = (w_prevEff < i_curValue) ? w_prevEff : i_curValue;
  assign w_hi  = (w_prevEff < i_curValue) ? i_curValue : w_prevEff;
  assign o_hit = i_enable && (i_row >= w_lo) && (i_row <= w_hi);

endmodule

// File: rtl/wave_display_mc.sv
// -----------------------------------------------------------------------------
// wave_display_mc
//   Overlays up to CHANNELS waveforms inside a screen window. The RAM address
//   is generated one column ahead so the synchronous RAM data lines up with
//   the current column. The display bank is latched only at frame start to
//   avoid tearing. Output pixel and colour are registered (latency 1).
// Ports
//   clk, reset      pixel clock, asynchronous active-high reset
//   x, y, valid     raster position from the timing generator
//   read_index      requested bank, latched at x==0,y==0 while valid
//   ch_en           per-channel enable
//   read_address    {bank, sample index} to the shared sample RAM
//   read_value      per-channel RAM data, one cycle after the address
//   valid_pixel     some enabled trace covers the previous (x,y)
//   r, g, b         colour of the lowest-numbered hit channel, else 0
// -----------------------------------------------------------------------------
module wave_display_mc
  import wave_display_mc_pkg::*;
#(
  parameter int                     CHANNELS = 2,
  parameter int                     VALUE_W  = VALUE_W_DEF,
  parameter int                     SAMPLE_W = SAMPLE_W_DEF,
  parameter int                     X_SHIFT  = 1,
  parameter int                     X0       = 256,
  parameter int                     Y_SHIFT  = 1,
  parameter int                     X_MAX    = X_MAX_DEF,
  parameter logic [CHANNELS*24-1:0] COLORS   = COLORS_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [10:0]                  x,
  input  logic [9:0]                   y,
  input  logic                         valid,
  input  logic                         read_index,
  input  logic [CHANNELS-1:0]          ch_en,
  output logic [SAMPLE_W:0]            read_address,
  input  logic [CHANNELS*VALUE_W-1:0]  read_value,
  output logic                         valid_pixel,
  output logic [7:0]                   r,
  output logic [7:0]                   g,
  output logic [7:0]                   b
);

  // Window bounds held in 12 bits so a window ending exactly at column 2047
  // still compares correctly against the 11-bit column.
  localparam int          WIN_W    = 2 ** (SAMPLE_W + X_SHIFT);
  localparam logic [11:0] X0_C     = 12'(X0);
  localparam logic [11:0] X_END_C  = 12'(X0 + WIN_W);
  localparam logic [10:0] X_MAX_C  = 11'(X_MAX);
  localparam logic [10:0] Y_LIM_C  = 11'(2 ** (VALUE_W + Y_SHIFT));

  logic [10:0]         w_xl;
  logic [11:0]         w_xlOff;
  logic                w_xlIn;
  logic [SAMPLE_W-1:0] w_index;
  logic                w_xOk;
  logic                w_yOk;
  logic [VALUE_W-1:0]  w_row;
  logic                w_newSample;
  logic                w_firstSample;
  logic [CHANNELS-1:0] w_hit;
  logic [23:0]         w_color;
  logic                w_draw;

  logic                r_bank;
  logic [SAMPLE_W-1:0] r_idxQ;
  logic [SAMPLE_W-1:0] r_idxQq;
  logic                r_inWinQ;
  logic                r_inWinQq;
  logic                r_validPixel;
  rgb_t                r_color;

  // Lookahead column: the address is issued for the next column so the RAM
  // answer arrives while that column is current. End of line wraps to 0.
  assign w_xl    = (x == X_MAX_C) ? 11'd0 : x + 11'd1;
  assign w_xlIn  = ({1'b0, w_xl} >= X0_C) && ({1'b0, w_xl} < X_END_C);
  assign w_xlOff = {1'b0, w_xl} - X0_C;
  assign w_index = w_xlIn ? SAMPLE_W'(w_xlOff >> X_SHIFT) : '0;

  assign read_address = {r_bank, w_index};

  assign w_xOk = ({1'b0, x} >= X0_C) && ({1'b0, x} < X_END_C);
  assign w_yOk = ({1'b0, y} < Y_LIM_C);
  assign w_row = VALUE_W'(y >> Y_SHIFT);

  // Bank select only moves at the very first active pixel of a frame, so a
  // writer swapping buffers mid-frame never tears the picture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_bank <= 1'b0;
    else if (valid && (x == 11'd0) && (y == 10'd0))
      r_bank <= read_index;
  end

  // Index/window history. r_idxQ and r_inWinQ describe the current column
  // (the one whose sample is on read_value); the Qq copies describe the
  // column before it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idxQ    <= '0;
      r_idxQq   <= '0;
      r_inWinQ  <= 1'b0;
      r_inWinQq <= 1'b0;
    end else begin
      r_idxQ    <= w_index;
      r_idxQq   <= r_idxQ;
      r_inWinQ  <= w_xlIn;
      r_inWinQq <= r_inWinQ;
    end
  end

  assign w_newSample   = r_inWinQ && (r_idxQ != r_idxQq);
  assign w_firstSample = r_inWinQ && !r_inWinQq;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_span
    wave_display_mc_span_ch #(
      .VALUE_W (VALUE_W)
    ) u_span (
      .clk           (clk),
      .reset         (reset),
      .i_curValue    (read_value[c*VALUE_W +: VALUE_W]),
      .i_newSample   (w_newSample),
      .i_firstSample (w_firstSample),
      .i_enable      (ch_en[c]),
      .i_row         (w_row),
      .o_hit         (w_hit[c])
    );
  end

  // Lowest-numbered channel wins, so scan from the top down and let lower
  // channels overwrite.
  always_comb begin
    w_color = COLOR_BLACK;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (w_hit[c])
        w_color = COLORS[c*24 +: 24];
    end
  end

  // r_inWinQ guards against drawing before the history describes this
  // column, e.g. the first cycle after reset released mid-window.
  assign w_draw = valid && w_xOk && r_inWinQ && w_yOk && (|w_hit);

  // Registered output stage; colour is forced black whenever nothing is drawn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_validPixel <= 1'b0;
      r_color      <= '0;
    end else begin
      r_validPixel <= w_draw;
      r_color      <= w_draw ? rgb_t'(w_color) : '0;
    end
  end

  assign valid_pixel = r_validPixel;
  assign r           = r_color.red;
  assign g           = r_color.green;
  assign b           = r_color.blue;

endmodule

// File: tb/tb_wave_display_mc.sv
// -----------------------------------------------------------------------------
// tb_wave_display_mc
//   Self-checking bench for wave_display_mc with a two-bank, two-channel
//   sample RAM model and a queue of expected pixels.
// -----------------------------------------------------------------------------
module tb_wave_display_mc;

  typedef struct {
    logic [24:0] expPix;
    int          px;
    int          py;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid;
  logic        readIndex;
  logic [1:0]  chEn;
  logic [8:0]  readAddress;
  logic [15:0] readValue;
  logic        validPixel;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;

  logic [7:0]  mem0 [512];
  logic [7:0]  mem1 [512];
  exp_t        expQ [$];
  int          checks = 0;
  int          errors = 0;
  int          modelBank = 0;

  wave_display_mc dut (
    .clk          (clk),
    .reset        (reset),
    .x            (x),
    .y            (y),
    .valid        (valid),
    .read_index   (readIndex),
    .ch_en        (chEn),
    .read_address (readAddress),
    .read_value   (readValue),
    .valid_pixel  (validPixel),
    .r            (r),
    .g            (g),
    .b            (b)
  );

  always #5 clk = ~clk;

  // Synchronous-read sample RAM, channel 0 in the low byte.
  always @(posedge clk) readValue <= {mem1[readAddress], mem0[readAddress]};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: column x shows sample k=(x-256)/2 spanning from sample k-1
  // (or a dot for k==0), rows scaled by 2, lowest enabled channel wins.
  function automatic logic [24:0] expectPixel(int px, int py, logic pv,
                                              logic [1:0] en, int bank);
    logic [24:0] res;
    int k, yy, cur, prv, lo, hi;
    res = '0;
    if (!pv || px < 256 || px >= 768 || py >= 512) return res;
    k  = (px - 256) / 2;
    yy = py / 2;
    for (int c = 1; c >= 0; c--) begin
      cur = (c == 1) ? int'(mem1[bank*256 + k]) : int'(mem0[bank*256 + k]);
      if (k == 0)
        prv = cur;
      else
        prv = (c == 1) ? int'(mem1[bank*256 + k - 1]) : int'(mem0[bank*256 + k - 1]);
      lo = (prv < cur) ? prv : cur;
      hi = (prv < cur) ? cur : prv;
      if (en[c] && yy >= lo && yy <= hi)
        res = {1'b1, (c == 1) ? 24'h00FF00 : 24'h8A2BE2};
    end
    return res;
  endfunction

  // Scoreboard consumer: the output registered at this edge belongs to the
  // inputs driven at the preceding falling edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput($sformatf("pix x=%0d y=%0d", e.px, e.py),
                  {7'd0, validPixel, r, g, b}, {7'd0, e.expPix});
    end
  end

  task automatic applyStimulus(input int px, input int py, input logic pv,
                               input bit push);
    exp_t e;
    @(negedge clk);
    x     = 11'(px);
    y     = 10'(py);
    valid = pv;
    if (pv && px == 0 && py == 0) modelBank = int'(readIndex);
    if (push) begin
      e.expPix = expectPixel(px, py, pv, chEn, modelBank);
      e.px     = px;
      e.py     = py;
      expQ.push_back(e);
    end
  endtask

  task automatic sweepLine(input int py, input int xFirst, input int xLast);
    for (int px = xFirst; px <= xLast; px++) applyStimulus(px, py, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic checkAddr(input string tag, input int px, input logic [8:0] expAddr);
    applyStimulus(px, 100, 1'b1, 1'b0);
    #1;
    checkOutput(tag, {23'd0, readAddress}, {23'd0, expAddr});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; x = '0; y = '0; valid = 1'b0; readIndex = 1'b0; chEn = 2'b00;
    for (int k = 0; k < 256; k++) begin
      mem0[k] = 8'(k);        mem1[k] = 8'(k);
      mem0[256+k] = 8'(255-k); mem1[256+k] = 8'(255-k);
    end

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset valid_pixel", {31'd0, validPixel}, 32'd0);
    checkOutput("reset rgb", {8'd0, r, g, b}, 32'd0);
    checkOutput("reset address", {23'd0, readAddress}, 32'd0);
    reset = 1'b0;

    // Ramp on channel 0 at several rows
    chEn = 2'b01;
    sweepLine(0, 250, 775);
    sweepLine(10, 250, 775);
    sweepLine(200, 250, 775);
    sweepLine(510, 250, 775);

    // Step 10 -> 200 between samples 5 and 6 on both channels
    for (int k = 0; k < 256; k++) begin
      mem0[k] = (k <= 5) ? 8'd10 : 8'd200;
      mem1[k] = mem0[k];
    end
    sweepLine(200, 250, 300);
    chEn = 2'b11; sweepLine(200, 250, 300);
    chEn = 2'b10; sweepLine(200, 250, 300);
    chEn = 2'b00; sweepLine(200, 250, 300);

    // Row limit: value 255 reachable at y=510/511, not at y=512
    for (int k = 0; k < 256; k++) mem0[k] = 8'd255;
    chEn = 2'b01;
    sweepLine(511, 250, 775);
    sweepLine(512, 250, 775);

    // Lookahead addressing, including end-of-line wrap
    checkAddr("addr x=255", 255, 9'd0);
    checkAddr("addr x=257", 257, 9'd1);
    checkAddr("addr x=766", 766, 9'd255);
    checkAddr("addr x=767", 767, 9'd0);
    checkAddr("addr x=X_MAX", 1279, 9'd0);

    // Bank latch only at frame start
    for (int k = 0; k < 256; k++) begin mem0[k] = 8'(k); mem1[k] = 8'(k); end
    chEn = 2'b00;
    readIndex = 1'b1;
    applyStimulus(600, 40, 1'b1, 1'b0);
    @(posedge clk); #1;
    checkOutput("bank mid-frame", {31'd0, readAddress[8]}, 32'd0);
    applyStimulus(0, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("bank blanked origin", {31'd0, readAddress[8]}, 32'd0);
    applyStimulus(0, 0, 1'b1, 1'b0);
    @(posedge clk); #1;
    checkOutput("bank frame start", {31'd0, readAddress[8]}, 32'd1);
    readIndex = 1'b0;
    applyStimulus(10, 5, 1'b1, 1'b0);
    @(posedge clk); #1;
    checkOutput("bank held", {31'd0, readAddress[8]}, 32'd1);
    chEn = 2'b01;
    sweepLine(310, 250, 775);

    // Reset mid-line while a pixel is lit
    sweepLine(346, 250, 420);
    @(negedge clk);
    x = 11'd421;
    #1 reset = 1'b1;
    #1;
    modelBank = 0;
    checkOutput("midline reset valid_pixel", {31'd0, validPixel}, 32'd0);
    checkOutput("midline reset rgb", {8'd0, r, g, b}, 32'd0);
    checkOutput("midline reset bank", {31'd0, readAddress[8]}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sweepLine(20, 250, 775);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
